wm8731_cfg_sched: RTL and testbench

WM8731_CFG_SCHED -- requirements
Module: wm8731_cfg_sched

---
 rtl/wm8731_pkg.sv | 28 ++
 rtl/cfg_req_slot.sv | 42 ++++
 rtl/wm8731_cfg_sched.sv | 188 ++++++++++++++++++
 tb/tb_wm8731_cfg_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 configuration scheduler.
// Holds the FSM state enum, register addresses, volume codes and word packing.
package wm8731_pkg;

    typedef enum logic [2:0] {
        StInitFetch,
        StInitWr,
        StReady,
        StRtWr,
        StErr
    } cfg_state_e;

    localparam logic [6:0] RegHpVol    = 7'h02;
    localparam logic [6:0] RegDacCtrl  = 7'h05;
    localparam logic [6:0] VolMuteCode = 7'h2F;
    localparam logic [6:0] VolReset    = 7'h79;

    // Codes at or below the mute code are all silent on the part; write the canonical one.
    function automatic logic [6:0] clamp_vol(input logic [6:0] vol);
        return (vol <= VolMuteCode) ? VolMuteCode : vol;
    endfunction

    function automatic logic [15:0] pack_word(input logic [6:0] reg_addr,
                                              input logic [8:0] reg_data);
        return {reg_addr, reg_data};
    endfunction

endpackage

// File: rtl/cfg_req_slot.sv
// One pending-request slot: a flag plus the newest requested value.
// A set in the same cycle as a clear wins, so a late request is never lost.
module cfg_req_slot #(
    parameter int unsigned Width = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_i,
    input  logic [Width-1:0] set_val_i,
    input  logic             clr_i,
    output logic             pending_o,
    output logic [Width-1:0] value_o
);

    logic             pending_q, pending_d;
    logic [Width-1:0] value_q, value_d;

    always_comb begin
        pending_d = pending_q;
        value_d   = value_q;
        if (set_i) begin
            pending_d = 1'b1;
            value_d   = set_val_i;
        end else if (clr_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            value_q   <= '0;
        end else begin
            pending_q <= pending_d;
            value_q   <= value_d;
        end
    end

    assign pending_o = pending_q;
    assign value_o   = value_q;

endmodule

// File: rtl/wm8731_cfg_sched.sv
// WM8731 register write scheduler: init table, then coalesced mute/volume writes with retry.
// Define CFG_SCHED_ZC_EN to set the zero-cross bit on headphone volume writes.
module wm8731_cfg_sched
    import wm8731_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR  = 8'h34,
    parameter int unsigned INIT_LEN  = 10,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  lut_index,
    input  logic [15:0] lut_data,
    input  logic        vol_req,
    input  logic [6:0]  vol_val,
    input  logic        mute_req,
    input  logic        mute_en,
    output logic        wr_req,
    output logic [7:0]  wr_dev_addr,
    output logic [7:0]  wr_byte0,
    output logic [7:0]  wr_byte1,
    input  logic        wr_ack,
    input  logic        wr_err,
    output logic        init_done,
    output logic        busy,
    output logic        err,
    output logic [6:0]  vol_cur
);

`ifdef CFG_SCHED_ZC_EN
    localparam logic ZcBit = 1'b1;
`else
    localparam logic ZcBit = 1'b0;
`endif

    cfg_state_e  state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic [15:0] word_q, word_d;
    logic        req_q, req_d;
    logic [7:0]  byte0_q, byte0_d, byte1_q, byte1_d;
    logic [7:0]  fail_q, fail_d;
    logic        init_done_q, init_done_d;
    logic        err_q, err_d;
    logic [6:0]  vol_cur_q, vol_cur_d;
    logic        sel_mute_q, sel_mute_d;

    logic        vol_pend, mute_pend, vol_clr, mute_clr, mute_val;
    logic [6:0]  vol_slot;

    cfg_req_slot #(.Width(7)) u_vol_slot (
        .clk_i     (clk),
        .rst_i     (rst),
        .set_i     (vol_req),
        .set_val_i (vol_val),
        .clr_i     (vol_clr),
        .pending_o (vol_pend),
        .value_o   (vol_slot)
    );

    cfg_req_slot #(.Width(1)) u_mute_slot (
        .clk_i     (clk),
        .rst_i     (rst),
        .set_i     (mute_req),
        .set_val_i (mute_en),
        .clr_i     (mute_clr),
        .pending_o (mute_pend),
        .value_o   (mute_val)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        word_d      = word_q;
        req_d       = req_q;
        byte0_d     = byte0_q;
        byte1_d     = byte1_q;
        fail_d      = fail_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        vol_cur_d   = vol_cur_q;
        sel_mute_d  = sel_mute_q;
        vol_clr     = 1'b0;
        mute_clr    = 1'b0;

        case (state_q)
            StInitFetch: begin
                word_d  = lut_data;
                fail_d  = '0;
                state_d = StInitWr;
            end
            StInitWr, StRtWr: begin
                // A low wr_req here is either the first cycle of a write or the retry gap.
                if (!req_q) begin
                    req_d   = 1'b1;
                    byte0_d = word_q[15:8];
                    byte1_d = word_q[7:0];
                end else if (wr_ack) begin
                    req_d  = 1'b0;
                    fail_d = '0;
                    if (state_q == StInitWr) begin
                        idx_d = idx_q + 10'd1;
                        if (idx_d == 10'(INIT_LEN)) begin
                            state_d     = StReady;
                            init_done_d = 1'b1;
                        end else begin
                            state_d = StInitFetch;
                        end
                    end else begin
                        state_d = StReady;
                        if (!sel_mute_q) begin
                            vol_cur_d = word_q[6:0];
                        end
                    end
                end else if (wr_err) begin
                    req_d = 1'b0;
                    if (fail_q == 8'(RETRY_MAX)) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        fail_d = fail_q + 8'd1;
                    end
                end
            end
            StReady: begin
                // Slots are cleared at launch so a request during the write stays pending.
                if (mute_pend) begin
                    word_d     = pack_word(RegDacCtrl, {5'b0, mute_val, 3'b0});
                    sel_mute_d = 1'b1;
                    mute_clr   = 1'b1;
                    fail_d     = '0;
                    state_d    = StRtWr;
                end else if (vol_pend) begin
                    word_d     = pack_word(RegHpVol, {1'b1, ZcBit, clamp_vol(vol_slot)});
                    sel_mute_d = 1'b0;
                    vol_clr    = 1'b1;
                    fail_d     = '0;
                    state_d    = StRtWr;
                end
            end
            StErr: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = StInitFetch;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInitFetch;
            idx_q       <= '0;
            word_q      <= '0;
            req_q       <= 1'b0;
            byte0_q     <= '0;
            byte1_q     <= '0;
            fail_q      <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            vol_cur_q   <= VolReset;
            sel_mute_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            req_q       <= req_d;
            byte0_q     <= byte0_d;
            byte1_q     <= byte1_d;
            fail_q      <= fail_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            vol_cur_q   <= vol_cur_d;
            sel_mute_q  <= sel_mute_d;
        end
    end

    assign lut_index   = idx_q;
    assign wr_req      = req_q;
    assign wr_dev_addr = DEV_ADDR;
    assign wr_byte0    = byte0_q;
    assign wr_byte1    = byte1_q;
    assign init_done   = init_done_q;
    assign err         = err_q;
    assign vol_cur     = vol_cur_q;
    assign busy        = (state_q != StErr) &&
                         (req_q || vol_pend || mute_pend || !init_done_q || state_q == StRtWr);

endmodule

// File: tb/tb_wm8731_cfg_sched.sv
// Self-checking bench for wm8731_cfg_sched: init table, coalescing, priority, retry/error, reset.
module tb_wm8731_cfg_sched;

`ifdef CFG_SCHED_ZC_EN
    localparam logic [7:0] ZC = 8'h80;
`else
    localparam logic [7:0] ZC = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  lut_index;
    logic [15:0] lut_data;
    logic        vol_req = 1'b0;
    logic [6:0]  vol_val = '0;
    logic        mute_req = 1'b0;
    logic        mute_en = 1'b0;
    logic        wr_req;
    logic [7:0]  wr_dev_addr, wr_byte0, wr_byte1;
    logic        wr_ack, wr_err;
    logic        init_done, busy, err;
    logic [6:0]  vol_cur;

    wm8731_cfg_sched dut (
        .clk         (clk),
        .rst         (rst),
        .lut_index   (lut_index),
        .lut_data    (lut_data),
        .vol_req     (vol_req),
        .vol_val     (vol_val),
        .mute_req    (mute_req),
        .mute_en     (mute_en),
        .wr_req      (wr_req),
        .wr_dev_addr (wr_dev_addr),
        .wr_byte0    (wr_byte0),
        .wr_byte1    (wr_byte1),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .init_done   (init_done),
        .busy        (busy),
        .err         (err),
        .vol_cur     (vol_cur)
    );

    always #5 clk = ~clk;

    logic [15:0] lut_tbl [10];
    always_comb begin
        lut_data = 16'h0000;
        if (lut_index < 10'd10) lut_data = lut_tbl[lut_index[3:0]];
    end

    int          total = 0;
    int          passed = 0;
    int          attempts = 0;
    int          stab_bad = 0;
    int          rcnt = 0;
    bit          fail_all = 1'b0;
    logic [15:0] held = '0;
    logic [15:0] wlog [$];

    // I2C master stand-in: answers each write 5 cycles after wr_req rises.
    initial begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            wr_ack = 1'b0;
            wr_err = 1'b0;
            if (wr_req && !rst) begin
                if (rcnt == 0) begin
                    attempts++;
                    held = {wr_byte0, wr_byte1};
                end else if ({wr_byte0, wr_byte1} != held) begin
                    stab_bad++;
                end
                rcnt++;
                if (rcnt == 5) begin
                    if (fail_all) wr_err = 1'b1;
                    else begin
                        wr_ack = 1'b1;
                        wlog.push_back(held);
                    end
                    rcnt = 0;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_vol(input logic [6:0] v);
        vol_val = v; vol_req = 1'b1;
        tick();
        vol_req = 1'b0;
    endtask

    task automatic pulse_mute(input logic m);
        mute_en = m; mute_req = 1'b1;
        tick();
        mute_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        tick();
        while (busy && n < 300) begin tick(); n++; end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!init_done && n < 400) begin tick(); n++; end
        check(name, 32'(init_done), 32'd1);
    endtask

    typedef struct {
        bit         is_mute;
        logic [6:0] val;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [6:0] vcur;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n;
        int base;
        lut_tbl = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                    16'h0812, 16'h0A00, 16'h0C00, 16'h0E02, 16'h1201};
        vecs[0] = '{1'b0, 7'h60, 8'h05, ZC | 8'h60, 7'h60};
        vecs[1] = '{1'b0, 7'h30, 8'h05, ZC | 8'h30, 7'h30};
        vecs[2] = '{1'b0, 7'h2F, 8'h05, ZC | 8'h2F, 7'h2F};
        vecs[3] = '{1'b0, 7'h00, 8'h05, ZC | 8'h2F, 7'h2F};
        vecs[4] = '{1'b1, 7'h01, 8'h0A, 8'h08,      7'h2F};
        vecs[5] = '{1'b1, 7'h00, 8'h0A, 8'h00,      7'h2F};
        vecs[6] = '{1'b0, 7'h7F, 8'h05, ZC | 8'h7F, 7'h7F};

        // Reset state.
        tick(); tick();
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_dev_addr", 32'(wr_dev_addr), 32'h34);
        check("rst_bytes", 32'({wr_byte0, wr_byte1}), 32'd0);
        check("rst_lut_index", 32'(lut_index), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_vol_cur", 32'(vol_cur), 32'h79);
        check("rst_busy", 32'(busy), 32'd1);

        // First wr_req exactly two cycles after reset release.
        rst = 1'b0;
        tick();
        check("first_req_cyc1", 32'(wr_req), 32'd0);
        tick();
        check("first_req_cyc2", 32'(wr_req), 32'd1);

        // Volume requests during init coalesce to the newest.
        pulse_vol(7'h40);
        tick(); tick();
        pulse_vol(7'h50);
        tick();
        pulse_vol(7'h70);
        wait_init("init_done_seen");
        check("init_lut_index", 32'(lut_index), 32'd10);
        check("init_log_len", 32'(wlog.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < wlog.size()) check($sformatf("init_word%0d", i), 32'(wlog[i]), 32'(lut_tbl[i]));
        end
        wait_idle("coalesce_idle");
        check("coalesce_log_len", 32'(wlog.size()), 32'd11);
        if (wlog.size() >= 11) check("coalesce_word", 32'(wlog[10]), 32'({8'h05, ZC | 8'h70}));
        check("coalesce_vol_cur", 32'(vol_cur), 32'h70);

        // Table-driven runtime writes.
        for (int i = 0; i < 7; i++) begin
            base = wlog.size();
            if (vecs[i].is_mute) pulse_mute(vecs[i].val[0]);
            else pulse_vol(vecs[i].val);
            wait_idle($sformatf("vec%0d_idle", i));
            check($sformatf("vec%0d_count", i), 32'(wlog.size() - base), 32'd1);
            if (wlog.size() > base) begin
                check($sformatf("vec%0d_byte0", i), 32'(wlog[base][15:8]), 32'(vecs[i].b0));
                check($sformatf("vec%0d_byte1", i), 32'(wlog[base][7:0]), 32'(vecs[i].b1));
            end
            check($sformatf("vec%0d_vol_cur", i), 32'(vol_cur), 32'(vecs[i].vcur));
        end

        // Mute and volume in the same cycle: mute goes first.
        base = wlog.size();
        mute_en = 1'b1; mute_req = 1'b1; vol_val = 7'h10; vol_req = 1'b1;
        tick();
        mute_req = 1'b0; vol_req = 1'b0;
        wait_idle("prio_idle");
        check("prio_count", 32'(wlog.size() - base), 32'd2);
        if (wlog.size() >= base + 2) begin
            check("prio_first", 32'(wlog[base]), 32'h0A08);
            check("prio_second", 32'(wlog[base+1]), 32'({8'h05, ZC | 8'h2F}));
        end
        check("prio_vol_cur", 32'(vol_cur), 32'h2F);

        // Request landing in the same cycle as the ack of its own slot stays pending.
        base = wlog.size();
        pulse_vol(7'h40);
        n = 0;
        @(negedge clk);
        while (!wr_ack && n < 100) begin @(negedge clk); n++; end
        check("same_cyc_ack_seen", 32'(wr_ack), 32'd1);
        vol_val = 7'h50; vol_req = 1'b1;
        tick();
        vol_req = 1'b0;
        wait_idle("same_cyc_idle");
        check("same_cyc_count", 32'(wlog.size() - base), 32'd2);
        if (wlog.size() >= base + 2) check("same_cyc_second", 32'(wlog[base+1][6:0]), 32'h50);
        check("same_cyc_vol_cur", 32'(vol_cur), 32'h50);

        // Every attempt fails: four attempts, then sticky error.
        attempts = 0;
        fail_all = 1'b1;
        pulse_vol(7'h44);
        n = 0;
        while (!err && n < 200) begin tick(); n++; end
        check("err_set", 32'(err), 32'd1);
        check("err_attempts", 32'(attempts), 32'd4);
        check("err_wr_req", 32'(wr_req), 32'd0);
        check("err_busy", 32'(busy), 32'd0);
        pulse_mute(1'b1);
        repeat (20) tick();
        check("err_no_more_attempts", 32'(attempts), 32'd4);
        check("err_still_set", 32'(err), 32'd1);
        check("err_vol_cur_kept", 32'(vol_cur), 32'h50);

        // Reset clears the error; reset mid-write restarts init from entry 0.
        fail_all = 1'b0;
        rst = 1'b1;
        tick(); tick();
        check("rerst_err", 32'(err), 32'd0);
        check("rerst_init_done", 32'(init_done), 32'd0);
        check("rerst_vol_cur", 32'(vol_cur), 32'h79);
        rst = 1'b0;
        n = 0;
        while (!wr_req && n < 20) begin tick(); n++; end
        check("midwr_req_up", 32'(wr_req), 32'd1);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midwr_req_drop", 32'(wr_req), 32'd0);
        check("midwr_lut_index", 32'(lut_index), 32'd0);
        rst = 1'b0;
        wlog.delete();
        wait_init("reinit_done");
        check("reinit_log_len", 32'(wlog.size()), 32'd10);
        if (wlog.size() >= 10) begin
            check("reinit_first", 32'(wlog[0]), 32'(lut_tbl[0]));
            check("reinit_last", 32'(wlog[9]), 32'(lut_tbl[9]));
        end
        wait_idle("reinit_idle");
        check("reinit_no_stale_req", 32'(wlog.size()), 32'd10);

        check("wr_bytes_stable", 32'(stab_bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
